bus_endpoint: RTL and testbench
===============================

# bus_endpoint

Device-side endpoint for one port of the `bs_gnrtr_n_rbtr` bus. It is the RTL counterpart of the testbench FIFO emulation. A transmit FIFO is loaded by the local host and drained by the bus through `pndng`/`pop`/`D_pop`. A receive FIFO captures bus deliveries on `push`/`D_push` and drains them to the host. One instance sits on each of the `drvrs` bus ports.

## Interface
- `pckg_sz`, 16: packet width in bits. Bits `[pckg_sz-1 -: 8]` hold the destination ID; the rest is payload.
- `depth`, 8: entries per FIFO, power of two, at least 2.
- `id`, 0: this endpoint's 8-bit port ID.
- `broadcast`, 8'hFF: destination ID accepted by all endpoints.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-low reset.
- `pndng` out 1: TX FIFO is non-empty (bus side).
- `D_pop` out `pckg_sz`: TX head packet (bus side).
- `pop` in 1: bus consumes the TX head.
- `push` in 1: bus delivers a packet.
- `D_push` in `pckg_sz`: the delivered packet.
- `wr_en` in 1: host writes a TX packet.
- `wr_data` in `pckg_sz`: the TX packet.
- `tx_full` out 1: TX FIFO is full.
- `rd_en` in 1: host consumes the RX head.
- `rd_data` out `pckg_sz`: RX head packet.
- `rd_valid` out 1: RX FIFO is non-empty.
- `tx_ovf` out 1: sticky flag, write attempted while full.
- `rx_ovf` out 1: sticky flag, push arrived while RX full.
- `pop_err` out 1: sticky flag, pop arrived with `pndng=0`.
- `drop_cnt` out 8: saturating count of dropped RX packets.

## Operation
- **Reset** (`reset=0` at a `clk` edge):
  - Both FIFOs are emptied and all pointers cleared.
  - `pndng`, `tx_full`, `rd_valid`, the three sticky flags and `drop_cnt` all go to 0.
  - `D_pop` and `rd_data` go to 0.
  - Reset mid-operation discards all stored packets.
- **Output convention:** both FIFOs are first-word-fall-through. `D_pop` equals the TX head when `pndng=1`, otherwise 0. `rd_data` follows the same rule with `rd_valid`.
- **TX path:**
  - `wr_en` with `tx_full=0` enqueues `wr_data`.
  - `wr_en` with `tx_full=1` is ignored and sets `tx_ovf`.
  - The exception is `pop` in the same cycle as a full write: the write is accepted and the occupancy count stays at `depth`.
  - `pop` with `pndng=1` dequeues the head.
  - `pop` with `pndng=0` is ignored and sets `pop_err`.
- **RX path:**
  - `push` with the RX FIFO not full enqueues `D_push`.
  - `push` with the RX FIFO full drops the packet, sets `rx_ovf` and increments `drop_cnt`.
  - A `push` coinciding with `rd_en` on a full RX FIFO is accepted.
  - `rd_en` with `rd_valid=0` is ignored.
- **Counters and pointers:**
  - Occupancy counters are `$clog2(depth)+1` bits wide.
  - Read and write pointers wrap modulo `depth`.
  - `drop_cnt` saturates at 255.
- **Sticky flags** clear only on reset.
- **FIFO state machine** (per FIFO): EMPTY -> PARTIAL on write; PARTIAL -> FULL when the count reaches `depth`; FULL -> PARTIAL on read; PARTIAL -> EMPTY when the count reaches 0. A simultaneous read and write holds the state.

## Timing
- **TX latency:** a write at edge N makes `pndng=1` and `D_pop=wr_data` visible after edge N when the FIFO was empty. There is no combinational bypass from `wr_data` to `D_pop`.
- **Pop:** `pop` sampled high at edge N means `D_pop` shows the next entry, or `pndng=0`, after edge N.
- **Back-to-back pops:** `pop` may be held high on consecutive cycles, one packet per cycle.
- **RX latency:** `push` at edge N gives `rd_valid=1` after edge N.
- **Flags:** all flags and `drop_cnt` update at the same edge as the triggering event.
- **Combinational paths:** none from any input to any output.

## Configuration
- **`BUS_ENDPOINT_ADDR_FILTER_EN` defined:** a pushed packet is enqueued only if its destination ID equals `id` or `broadcast`. Mismatching packets are dropped and increment `drop_cnt`; they do not set `rx_ovf`.
- **Macro undefined:** every pushed packet is a candidate for the RX FIFO, and `drop_cnt` counts overflow drops only.

## Structure
- **Package `bus_endpoint_pkg`:**
  - `ID_W` = 8.
  - `BROADCAST_ID` = 8'hFF.
  - A function that extracts the destination ID from a packet of a given width.
- **Sub-module `endpoint_fifo`:**
  - Parameterised synchronous FWFT FIFO with ports `wr_en`, `wr_data`, `rd_en`, `rd_data`, `empty`, `full`, `count`.
  - Same `clk`/`reset`.
  - Instanced once for TX and once for RX.
  - Flags, drop counter and address filter live in the top level.

## Test plan
- **Reset:** assert reset mid-traffic with 3 packets in TX -> next cycle `pndng=0`, `D_pop=0`, all flags 0, `drop_cnt=0`.
- **TX ordering:** write 16'h0101, 16'h0203, then pop twice -> `D_pop` shows 16'h0101 then 16'h0203, then `pndng=0`.
- **TX overflow:** write 9 packets into `depth=8` -> `tx_full=1`, `tx_ovf=1`, the first 8 are popped in order. Write plus pop on a full TX FIFO -> the new packet is accepted.
- **RX overflow:** push 9 packets with no reads -> `rx_ovf=1`, `drop_cnt=1`, the 9th packet is lost.
- **Filter, macro defined, `id=2`:** push 16'h0211, 16'hFF22, 16'h0333 -> only 16'h0211 and 16'hFF22 are read, `drop_cnt=1`.
- **Pop on empty:** pop with `pndng=0` -> `pop_err=1` and pointers unchanged. Then a write followed by a pop -> the written packet is delivered correctly.

Source files
------------

// File: rtl/bus_endpoint_pkg.sv
// Shared types and helpers for the bus endpoint and its FIFOs.
// Optional feature macro used by bus_endpoint: BUS_ENDPOINT_ADDR_FILTER_EN.
package bus_endpoint_pkg;

    localparam int unsigned     ID_W         = 8;
    localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;
    // Widest packet the destination-ID helper can take.
    localparam int unsigned     PKT_MAX_W    = 256;

    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // Destination ID is the top ID_W bits of a pkt_w-bit packet.
    function automatic logic [ID_W-1:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned         pkt_w);
        logic [PKT_MAX_W-1:0] shifted;
        shifted = pkt >> (pkt_w - ID_W);
        return shifted[ID_W-1:0];
    endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered state machine
// (EMPTY/PARTIAL/FULL). rd_data reads as zero while empty. A write on a full
// FIFO is accepted only when a read happens in the same cycle.
module endpoint_fifo
    import bus_endpoint_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    fifo_state_e      state_q;
    logic             empty_q, full_q;
    logic             do_wr, do_rd;

    // Accept decisions and next pointer/count values.
    always_comb begin
        do_rd  = rd_en && !empty_q;
        do_wr  = wr_en && (!full_q || rd_en);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_wr) wptr_d = wptr_q + PTR_W'(1);
        if (do_rd) rptr_d = rptr_q + PTR_W'(1);
        if (do_wr && !do_rd)      cnt_d = cnt_q + CNT_W'(1);
        else if (do_rd && !do_wr) cnt_d = cnt_q - CNT_W'(1);
    end

    // Storage array; contents are don't-care while empty since rd_data is gated.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data;
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // State machine with registered empty/full flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FIFO_EMPTY;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            case (state_q)
                FIFO_EMPTY: begin
                    if (do_wr) begin
                        state_q <= FIFO_PARTIAL;
                        empty_q <= 1'b0;
                    end
                end
                FIFO_PARTIAL: begin
                    if (cnt_d == CNT_W'(DEPTH)) begin
                        state_q <= FIFO_FULL;
                        full_q  <= 1'b1;
                    end else if (cnt_d == '0) begin
                        state_q <= FIFO_EMPTY;
                        empty_q <= 1'b1;
                    end
                end
                FIFO_FULL: begin
                    if (do_rd && !do_wr) begin
                        state_q <= FIFO_PARTIAL;
                        full_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= FIFO_EMPTY;
                    empty_q <= 1'b1;
                    full_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = empty_q ? '0 : mem_q[rptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign count   = cnt_q;

endmodule

// File: rtl/bus_endpoint.sv
// Device-side endpoint for one bus port: a host-loaded TX FIFO drained by the
// bus and an RX FIFO filled by the bus and drained by the host, plus sticky
// error flags and a saturating RX drop counter.
// Define BUS_ENDPOINT_ADDR_FILTER_EN to accept only packets addressed to `id`
// or `broadcast`; mismatches are dropped and counted in drop_cnt.
module bus_endpoint
    import bus_endpoint_pkg::*;
#(
    parameter int unsigned     pckg_sz   = 16,
    parameter int unsigned     depth     = 8,
    parameter logic [ID_W-1:0] id        = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST_ID
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    input  logic               rd_en,
    output logic [pckg_sz-1:0] rd_data,
    output logic               rd_valid,
    output logic               tx_ovf,
    output logic               rx_ovf,
    output logic               pop_err,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned CNT_W = $clog2(depth) + 1;

    logic             tx_empty;
    logic             rx_empty, rx_full;
    logic [CNT_W-1:0] tx_count, rx_count;
    logic             rx_cand, filt_drop, ovf_drop;
    logic             tx_ovf_q, rx_ovf_q, pop_err_q;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             unused_cnt;

    assign unused_cnt = ^{tx_count, rx_count};

`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
    logic [ID_W-1:0] push_dest;
    assign push_dest = dest_id(PKT_MAX_W'(D_push), pckg_sz);
    assign rx_cand   = push && ((push_dest == id) || (push_dest == broadcast));
    assign filt_drop = push && !rx_cand;
`else
    logic unused_filter_cfg;
    assign unused_filter_cfg = ^{id, broadcast};
    assign rx_cand   = push;
    assign filt_drop = 1'b0;
`endif

    // A full RX FIFO still takes a push when the host reads in the same cycle.
    assign ovf_drop = rx_cand && rx_full && !rd_en;

    endpoint_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (D_pop),
        .empty   (tx_empty),
        .full    (tx_full),
        .count   (tx_count)
    );

    endpoint_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (rx_cand),
        .wr_data (D_push),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (rx_empty),
        .full    (rx_full),
        .count   (rx_count)
    );

    // Saturating increment for any dropped RX packet.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((ovf_drop || filt_drop) && (drop_cnt_q != 8'hFF))
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Sticky error flags and drop counter; cleared only by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            pop_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (wr_en && tx_full && !pop) tx_ovf_q  <= 1'b1;
            if (ovf_drop)                 rx_ovf_q  <= 1'b1;
            if (pop && tx_empty)          pop_err_q <= 1'b1;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pndng    = !tx_empty;
    assign rd_valid = !rx_empty;
    assign tx_ovf   = tx_ovf_q;
    assign rx_ovf   = rx_ovf_q;
    assign pop_err  = pop_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_endpoint.sv
// Self-checking bench for bus_endpoint: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_bus_endpoint;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  MY_ID = 8'd2;

    logic         clk = 1'b0;
    logic         reset;
    logic         pndng;
    logic [W-1:0] D_pop;
    logic         pop;
    logic         push;
    logic [W-1:0] D_push;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         tx_full;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         tx_ovf, rx_ovf, pop_err;
    logic [7:0]   drop_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [W-1:0] txq[$];
    logic [W-1:0] rxq[$];
    bit           m_tx_ovf, m_rx_ovf, m_pop_err;
    int           m_drop;

    always #5 clk = ~clk;

    bus_endpoint #(
        .pckg_sz   (W),
        .depth     (DEPTH),
        .id        (MY_ID),
        .broadcast (8'hFF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx_full  (tx_full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .tx_ovf   (tx_ovf),
        .rx_ovf   (rx_ovf),
        .pop_err  (pop_err),
        .drop_cnt (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit accepts(input logic [W-1:0] pkt);
`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
        return (pkt[15:8] == MY_ID) || (pkt[15:8] == 8'hFF);
`else
        return 1'b1;
`endif
    endfunction

    task automatic bump_drop();
        if (m_drop < 255) m_drop++;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_update();
        int tsz, rsz;
        bit pop_acc, wr_acc, cand, rd_acc;
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_tx_ovf = 0; m_rx_ovf = 0; m_pop_err = 0; m_drop = 0;
        end else begin
            tsz     = txq.size();
            pop_acc = pop && (tsz > 0);
            if (pop && tsz == 0) m_pop_err = 1;
            wr_acc  = wr_en && ((tsz < DEPTH) || pop_acc);
            if (wr_en && !wr_acc) m_tx_ovf = 1;
            if (pop_acc) void'(txq.pop_front());
            if (wr_acc)  txq.push_back(wr_data);

            rsz    = rxq.size();
            rd_acc = rd_en && (rsz > 0);
            cand   = push && accepts(D_push);
            if (push && !cand) bump_drop();
            if (rd_acc) void'(rxq.pop_front());
            if (cand) begin
                if ((rsz < DEPTH) || rd_acc) rxq.push_back(D_push);
                else begin
                    m_rx_ovf = 1;
                    bump_drop();
                end
            end
        end
    endtask

    task automatic compare_all();
        check("pndng",    pndng,    txq.size() != 0);
        check("D_pop",    D_pop,    (txq.size() != 0) ? txq[0] : '0);
        check("tx_full",  tx_full,  txq.size() == DEPTH);
        check("rd_valid", rd_valid, rxq.size() != 0);
        check("rd_data",  rd_data,  (rxq.size() != 0) ? rxq[0] : '0);
        check("tx_ovf",   tx_ovf,   m_tx_ovf);
        check("rx_ovf",   rx_ovf,   m_rx_ovf);
        check("pop_err",  pop_err,  m_pop_err);
        check("drop_cnt", drop_cnt, m_drop);
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic step(input bit rn, input bit w, input logic [W-1:0] wd,
                        input bit p, input bit ps, input logic [W-1:0] pd, input bit rd);
        reset = rn; wr_en = w; wr_data = wd; pop = p;
        push = ps; D_push = pd; rd_en = rd;
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(1, 0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, '0, 0, 0, '0, 0);
    endtask

    initial begin
        logic [W-1:0] pd;
        int           bias_w, bias_p, bias_s, bias_r;

        reset = 0; wr_en = 0; wr_data = '0; pop = 0; push = 0; D_push = '0; rd_en = 0;

        // Reset state
        do_reset();
        do_reset();
        check("rst_pndng", pndng, 0);
        check("rst_D_pop", D_pop, 0);
        check("rst_drop",  drop_cnt, 0);

        // TX ordering
        step(1, 1, 16'h0101, 0, 0, '0, 0);
        step(1, 1, 16'h0203, 0, 0, '0, 0);
        check("ord_head0", D_pop, 16'h0101);
        step(1, 0, '0, 1, 0, '0, 0);
        check("ord_head1", D_pop, 16'h0203);
        step(1, 0, '0, 1, 0, '0, 0);
        check("ord_empty", pndng, 0);

        // TX overflow: nine writes into eight entries
        for (int i = 0; i < 9; i++) step(1, 1, W'(16'h1000 + i), 0, 0, '0, 0);
        check("ovf_full",  tx_full, 1);
        check("ovf_flag",  tx_ovf, 1);
        check("ovf_head",  D_pop, 16'h1000);
        for (int i = 0; i < 8; i++) step(1, 0, '0, 1, 0, '0, 0);
        check("ovf_drained", pndng, 0);

        // Write plus pop on a full TX FIFO
        for (int i = 0; i < 8; i++) step(1, 1, W'(16'h2000 + i), 0, 0, '0, 0);
        step(1, 1, 16'hABCD, 1, 0, '0, 0);
        check("wp_full", tx_full, 1);
        check("wp_head", D_pop, 16'h2001);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 1, 0, '0, 0);
        check("wp_last", D_pop, 16'hABCD);
        step(1, 0, '0, 1, 0, '0, 0);

        // RX overflow: nine pushes, no reads
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 0, '0, 0, 1, W'(16'h0200 + i), 0);
        check("rxo_flag", rx_ovf, 1);
        check("rxo_drop", drop_cnt, 1);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, 0, '0, 1);
        check("rxo_last", rd_data, 16'h0207);
        step(1, 0, '0, 0, 0, '0, 1);
        check("rxo_empty", rd_valid, 0);

        // Push with read on a full RX FIFO is accepted
        for (int i = 0; i < 8; i++) step(1, 0, '0, 0, 1, W'(16'h0230 + i), 0);
        step(1, 0, '0, 0, 1, 16'h02EE, 1);
        check("rxr_drop", drop_cnt, 1);
        for (int i = 0; i < 8; i++) step(1, 0, '0, 0, 0, '0, 1);

        // Address filter
        do_reset();
        step(1, 0, '0, 0, 1, 16'h0211, 0);
        step(1, 0, '0, 0, 1, 16'hFF22, 0);
        step(1, 0, '0, 0, 1, 16'h0333, 0);
        check("flt_head0", rd_data, 16'h0211);
        step(1, 0, '0, 0, 0, '0, 1);
        check("flt_head1", rd_data, 16'hFF22);
        step(1, 0, '0, 0, 0, '0, 1);
`ifdef BUS_ENDPOINT_ADDR_FILTER_EN
        check("flt_drop",  drop_cnt, 1);
        check("flt_empty", rd_valid, 0);
`else
        check("flt_drop",  drop_cnt, 0);
        check("flt_third", rd_data, 16'h0333);
        step(1, 0, '0, 0, 0, '0, 1);
`endif

        // Pop on empty leaves pointers intact
        do_reset();
        step(1, 0, '0, 1, 0, '0, 0);
        check("pe_flag", pop_err, 1);
        check("pe_pndng", pndng, 0);
        step(1, 1, 16'h5A5A, 0, 0, '0, 0);
        check("pe_head", D_pop, 16'h5A5A);
        step(1, 0, '0, 1, 0, '0, 0);
        check("pe_empty", pndng, 0);

        // Reset mid-traffic with three packets queued and flags set
        for (int i = 0; i < 3; i++) step(1, 1, W'(16'h0300 + i), 0, 0, '0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, '0, 0, 1, W'(16'h0240 + i), 0);
        check("mid_pndng", pndng, 1);
        step(0, 1, 16'h7777, 1, 1, 16'h0299, 1);
        check("mid_pndng0", pndng, 0);
        check("mid_D_pop0", D_pop, 0);
        check("mid_flags", {tx_ovf, rx_ovf, pop_err}, 3'b000);
        check("mid_drop0", drop_cnt, 0);
        idle();

        // drop_cnt saturation
        for (int i = 0; i < DEPTH + 270; i++) step(1, 0, '0, 0, 1, W'(16'hFF00 + (i & 255)), 0);
        check("sat_drop", drop_cnt, 255);

        // Randomized traffic with shifting bias to reach both full and empty
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                bias_w = $urandom_range(10, 90);
                bias_p = $urandom_range(10, 90);
                bias_s = $urandom_range(10, 90);
                bias_r = $urandom_range(10, 90);
            end
            pd = W'($urandom);
            case ($urandom_range(0, 2))
                0: pd[15:8] = MY_ID;
                1: pd[15:8] = 8'hFF;
                default: ;
            endcase
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 99) < bias_w), W'($urandom),
                 ($urandom_range(0, 99) < bias_p),
                 ($urandom_range(0, 99) < bias_s), pd,
                 ($urandom_range(0, 99) < bias_r));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
